// File: rtl/transpose_pingpong_buf_if.sv
// Handshake bundle for transpose_pingpong_buf.
//   Write side: in_valid/in_ready with in_data (one N-lane row vector per beat)
//               and in_mode (read mode, used only on the row-0 beat).
//   Read side:  out_valid/out_ready with out_data (column vector, or a zigzag
//               scalar in lane 0), out_last (final beat of the block) and
//               out_eob (last nonzero coefficient in zigzag order).
//   slave  : the buffer itself.
//   master : the producer/consumer environment around it.
interface transpose_pingpong_buf_if #(
    parameter int DW = 12,
    parameter int N  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [N*DW-1:0]   out_data;
    logic              out_last;
    logic              out_eob;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, out_eob
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_eob
    );
endinterface

// File: rtl/transpose_pingpong_buf.sv
// Double-buffered N x N coefficient buffer between the DCT/quantiser and the
// entropy coder. Rows are written one per beat into the write bank; the read
// bank drains either as transposed columns (COL) or as a zigzag scalar stream
// (ZZ, or ZZ_TRUNC which stops at the last nonzero coefficient).
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset (control only; bank storage is not reset)
//   bus    - transpose_pingpong_buf_if.slave (write and read handshakes)
package transpose_pingpong_pkg;
    typedef enum logic [1:0] {
        MODE_COL      = 2'd0,
        MODE_ZZ       = 2'd1,
        MODE_ZZ_TRUNC = 2'd2,
        MODE_COL_ALT  = 2'd3   // behaves as COL
    } rd_mode_e;

    // Position of cell (r,c) in zigzag order for an n x n block. Diagonals
    // d = r + c are taken in order; odd diagonals run row-ascending, even
    // ones row-descending. Cells before diagonal d form a triangle (d < n) or
    // the full block minus the trailing triangle (d >= n).
    function automatic int zz_idx(input int n, input int r, input int c);
        int d, base, rmin, rmax;
        d    = r + c;
        base = (d < n) ? (d * (d + 1)) / 2
                       : n * n - ((2 * n - 1 - d) * (2 * n - d)) / 2;
        rmin = (d > n - 1) ? d - n + 1 : 0;
        rmax = (d < n - 1) ? d : n - 1;
        return d[0] ? base + (r - rmin) : base + (rmax - r);
    endfunction
endpackage

// One write lane: flags a nonzero coefficient and reports its zigzag index
// for the row currently being written.
module transpose_pingpong_lane #(
    parameter int DW = 12,
    parameter int N  = 8,
    parameter int J  = 0,
    parameter int LW = $clog2(N),
    parameter int CW = 2 * $clog2(N)
) (
    input  logic [LW-1:0] row,
    input  logic [DW-1:0] coef,
    output logic          nz,
    output logic [CW-1:0] idx
);
    import transpose_pingpong_pkg::*;
    assign nz  = |coef;
    assign idx = CW'(zz_idx(N, int'(row), J));
endmodule

module transpose_pingpong_buf #(
    parameter int DW = 12,
    parameter int N  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    transpose_pingpong_buf_if.slave       bus
);
    import transpose_pingpong_pkg::*;

    localparam int LW = $clog2(N);
    localparam int CW = 2 * LW;
    localparam int NN = N * N;

    logic [DW-1:0]  mem [2][N][N];
    logic           wbank, rbank;
    logic [1:0]     full, full_nxt;
    logic [LW-1:0]  wrow;
    logic [CW-1:0]  rcnt;
    rd_mode_e       mode   [2];
    logic [CW-1:0]  lastnz [2];

    logic                   wr_fire, wr_end, rd_fire, rd_end;
    logic [N-1:0]           lane_nz;
    logic [N-1:0][CW-1:0]   lane_idx;
    logic [CW-1:0]          lastnz_nxt;
    logic [LW-1:0]          sel_r, sel_c;
    logic                   rd_col, rd_last, rd_eob;

    // in_ready depends only on registered state, so a bank freed by the
    // reader becomes writable one cycle later.
    assign bus.in_ready  = !full[wbank];
    assign bus.out_valid = full[rbank];

    assign wr_fire = bus.in_valid && bus.in_ready;
    assign wr_end  = wr_fire && (wrow == LW'(N - 1));
    assign rd_fire = bus.out_valid && bus.out_ready;
    assign rd_end  = rd_fire && rd_last;

    // ---------------- write side ----------------
    for (genvar j = 0; j < N; j++) begin : g_lane
        transpose_pingpong_lane #(.DW(DW), .N(N), .J(j)) u_lane (
            .row  (wrow),
            .coef (bus.in_data[j*DW +: DW]),
            .nz   (lane_nz[j]),
            .idx  (lane_idx[j])
        );
    end

    // Running max of zigzag indices of nonzero coefficients; row 0 restarts it.
    always_comb begin
        lastnz_nxt = (wrow == '0) ? '0 : lastnz[wbank];
        for (int j = 0; j < N; j++)
            if (lane_nz[j] && lane_idx[j] > lastnz_nxt) lastnz_nxt = lane_idx[j];
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_fire)
            for (int j = 0; j < N; j++) mem[wbank][wrow][j] <= bus.in_data[j*DW +: DW];
    end

    // Write and read may finish different banks in the same cycle; a bank
    // cannot be both writable and readable, so the two updates never collide.
    always_comb begin
        full_nxt = full;
        if (rd_end) full_nxt[rbank] = 1'b0;
        if (wr_end) full_nxt[wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            full      <= '0;
            wrow      <= '0;
            rcnt      <= '0;
            mode[0]   <= MODE_COL;
            mode[1]   <= MODE_COL;
            lastnz[0] <= '0;
            lastnz[1] <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wrow          <= wrow + 1'b1;
                lastnz[wbank] <= lastnz_nxt;
                if (wrow == '0) mode[wbank] <= rd_mode_e'(bus.in_mode);
                if (wr_end) begin
                    wbank <= ~wbank;
                    wrow  <= '0;
                end
            end
            if (rd_fire) begin
                rcnt <= rcnt + 1'b1;
                if (rd_end) begin
                    rbank <= ~rbank;
                    rcnt  <= '0;
                end
            end
        end
    end

    // ---------------- read side ----------------
    // Inverse zigzag: each cell's index is a constant, so this is a bank of
    // compares against rcnt rather than any arithmetic.
    always_comb begin
        sel_r = '0;
        sel_c = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (rcnt == CW'(zz_idx(N, r, c))) begin
                    sel_r = LW'(r);
                    sel_c = LW'(c);
                end
    end

    always_comb begin
        rd_col  = (mode[rbank] == MODE_COL) || (mode[rbank] == MODE_COL_ALT);
        rd_eob  = !rd_col && (rcnt == lastnz[rbank]);
        if (rd_col)                          rd_last = (rcnt == CW'(N - 1));
        else if (mode[rbank] == MODE_ZZ_TRUNC) rd_last = rd_eob;
        else                                 rd_last = (rcnt == CW'(NN - 1));
    end

    always_comb begin
        bus.out_data = '0;
        if (bus.out_valid) begin
            if (rd_col)
                for (int i = 0; i < N; i++)
                    bus.out_data[i*DW +: DW] = mem[rbank][i][rcnt[LW-1:0]];
            else
                bus.out_data[DW-1:0] = mem[rbank][sel_r][sel_c];
        end
    end

    assign bus.out_last = bus.out_valid && rd_last;
    assign bus.out_eob  = bus.out_valid && rd_eob;
endmodule

// File: tb/tb_transpose_pingpong_buf.sv
// Scoreboard bench for transpose_pingpong_buf (DW=12, N=8). The writer pushes
// the expected read beats of each completed block, derived from a zigzag
// order list built by walking diagonals; a negedge monitor pops and compares
// every accepted output beat and checks that idle outputs are zero.
module tb_transpose_pingpong_buf;
    localparam int DW = 12;
    localparam int N  = 8;
    localparam int NN = N * N;

    typedef logic [N*DW-1:0] vec_t;
    typedef struct packed {
        vec_t data;
        logic last;
        logic eob;
    } beat_t;
    typedef logic [DW-1:0] blk_t [N][N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    transpose_pingpong_buf_if #(.DW(DW), .N(N)) bus();
    transpose_pingpong_buf #(.DW(DW), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    int    zz_r[$];
    int    zz_c[$];
    int    rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled
    bit    chk_lat = 1'b0;
    bit    gaps = 1'b0;
    int    acc_beats = 0;

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected beats of one block.
    task automatic expect_block(input blk_t m, input logic [1:0] md);
        beat_t b;
        int    lnz;
        if (md == 2'd1 || md == 2'd2) begin
            lnz = 0;
            for (int k = 0; k < NN; k++)
                if (m[zz_r[k]][zz_c[k]] != '0) lnz = k;
            for (int k = 0; k < NN; k++) begin
                b = '0;
                b.data[DW-1:0] = m[zz_r[k]][zz_c[k]];
                b.eob  = (k == lnz);
                b.last = (md == 2'd2) ? (k == lnz) : (k == NN - 1);
                exp_q.push_back(b);
                if (md == 2'd2 && k == lnz) break;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                b = '0;
                for (int i = 0; i < N; i++) b.data[i*DW +: DW] = m[i][k];
                b.last = (k == N - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Writes nrows rows; called and returns at posedge+1.
    task automatic write_block(input blk_t m, input logic [1:0] md, input int nrows);
        bit   ok;
        int   t;
        vec_t v;
        for (int r = 0; r < nrows; r++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            for (int j = 0; j < N; j++) v[j*DW +: DW] = m[r][j];
            bus.in_valid = 1'b1;
            bus.in_data  = v;
            bus.in_mode  = (r == 0) ? md : 2'($urandom);
            ok = 1'b0;
            t  = 0;
            while (!ok) begin
                @(negedge clk);
                if (chk_lat) chk("latency_pre", 128'(bus.out_valid), 128'(0));
                ok = bus.in_ready;
                @(posedge clk); #1;
                t++;
                if (!ok && t > 1000) begin
                    n_vec++; n_err++;
                    $display("FAIL write_timeout: row %0d never accepted", r);
                    summary_and_finish();
                end
            end
            acc_beats++;
        end
        bus.in_valid = 1'b0;
        if (nrows == N) expect_block(m, md);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic rand_block(output blk_t m, input int density);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = ($urandom_range(0, 99) < density) ? DW'($urandom) : '0;
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    beat_t mb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_beat: got data %0h", bus.out_data);
                    end else begin
                        mb = exp_q.pop_front();
                        chk("out_data", 128'(bus.out_data), 128'(mb.data));
                        chk("out_last", 128'(bus.out_last), 128'(mb.last));
                        chk("out_eob",  128'(bus.out_eob),  128'(mb.eob));
                    end
                end
            end else begin
                chk("idle_zero", 128'({bus.out_data, bus.out_last, bus.out_eob}), 128'(0));
            end
        end
    end

    initial begin
        #3000000;
        n_vec++; n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        summary_and_finish();
    end

    blk_t m, m1, m2, m3;
    bit   seen;
    int   t;

    initial begin
        // zigzag order by walking diagonals
        for (int d = 0; d <= 2 * N - 2; d++)
            for (int s = 0; s < N; s++) begin
                int r;
                r = d[0] ? s : N - 1 - s;
                if (d - r >= 0 && d - r < N) begin
                    zz_r.push_back(r);
                    zz_c.push_back(d - r);
                end
            end

        // Reset with a write offered
        bus.in_valid = 1'b1;
        bus.in_data  = vec_t'({$urandom, $urandom, $urandom});
        bus.in_mode  = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data",  128'(bus.out_data),  128'(0));
        chk("rst_out_last",  128'(bus.out_last),  128'(0));
        chk("rst_out_eob",   128'(bus.out_eob),   128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_no_valid", 128'(bus.out_valid), 128'(0));

        // COL with (r,c) = 8r+c, checking first-read latency
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m[r][c] = DW'(8 * r + c);
        chk_lat = 1'b1;
        write_block(m, 2'd0, N);
        chk_lat = 1'b0;
        chk("latency_rise", 128'(bus.out_valid), 128'(1));
        drain();

        // ZZ on the same data
        write_block(m, 2'd1, N);
        drain();

        // ZZ_TRUNC: sparse block then all-zero block
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m[r][c] = '0;
        m[0][0] = 12'd5;
        m[1][0] = 12'hFF9;
        write_block(m, 2'd2, N);
        m[0][0] = '0;
        m[1][0] = '0;
        write_block(m, 2'd2, N);
        drain();

        // Random blocks, random modes, gaps and output backpressure
        gaps = 1'b1;
        rdy_mode = 1;
        for (int b = 0; b < 12; b++) begin
            rand_block(m, (b % 3 == 0) ? 100 : int'($urandom_range(0, 15)));
            write_block(m, 2'($urandom_range(0, 3)), N);
        end
        drain();
        gaps = 1'b0;
        rdy_mode = 0;

        // Backpressure: both banks fill, then release
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        acc_beats = 0;
        rand_block(m1, 100);
        rand_block(m2, 100);
        rand_block(m3, 100);
        write_block(m1, 2'd0, N);
        write_block(m2, 2'd0, N);
        @(negedge clk);
        chk("bp_beats", 128'(acc_beats), 128'(16));
        chk("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
        @(posedge clk); #1;
        fork
            write_block(m3, 2'd0, N);
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_mode = 0;
                seen = 1'b0;
                t = 0;
                while (!seen && t < 100) begin
                    @(negedge clk);
                    t++;
                    if (bus.out_valid && bus.out_ready && bus.out_last) seen = 1'b1;
                    else chk("bp_ready_held", 128'(bus.in_ready), 128'(0));
                end
                chk("bp_last_seen", 128'(seen), 128'(1));
                chk("bp_ready_at_last", 128'(bus.in_ready), 128'(0));
                @(negedge clk);
                chk("bp_ready_after_last", 128'(bus.in_ready), 128'(1));
            end
        join
        drain();

        // Reset with block 0 half read and block 1 partly written
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        rand_block(m1, 100);
        rand_block(m2, 100);
        write_block(m1, 2'd0, N);
        write_block(m2, 2'd0, 3);
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 2;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_out_data",  128'(bus.out_data),  128'(0));
        chk("mid_rst_out_last",  128'(bus.out_last),  128'(0));
        chk("mid_rst_out_eob",   128'(bus.out_eob),   128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        rand_block(m3, 60);
        write_block(m3, 2'd0, N);
        drain();
        rand_block(m3, 10);
        write_block(m3, 2'd1, N);
        drain();

        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
        summary_and_finish();
    end
endmodule
